pif_led_fader: RTL and testbench
================================

PIF_LED_FADER -- requirements
Module: pif_led_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: PWM/level width; MAX_LEVEL = 2^PWM_BITS-1.
REQ-002 SHALL have parameter STEP_DIV, default 4096: xclk cycles per fade step (>=1).
REQ-003 SHALL have port xclk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port sys_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port red_req, input, 1: red on/off request level from the flasher.
REQ-006 SHALL have port green_req, input, 1: green on/off request level from the flasher.
REQ-007 SHALL have port red_pwm, output, 1: faded PWM drive to the red LED pin.
REQ-008 SHALL have port green_pwm, output, 1: faded PWM drive to the green LED pin.
REQ-009 SHALL have port busy, output, 1: high while either channel is in RISE or FALL.

Function
REQ-010 SHALL run one shared prescaler counting 0..STEP_DIV-1 and wrapping; tick is high for exactly the cycle the count equals STEP_DIV-1.
REQ-011 SHALL run one shared PWM counter counting 0..MAX_LEVEL-1 and wrapping, giving a period of MAX_LEVEL cycles.
REQ-012 SHALL give each channel a PWM_BITS-bit level register and a four-state FSM: OFF, RISE, ON, FALL.
REQ-013 OFF: level 0; req=1 -> RISE on the next edge.
REQ-014 RISE: level+1 on each tick; the tick that makes level MAX_LEVEL -> ON; req=0 -> FALL on the next edge, level held unless that same cycle is a tick.
REQ-015 ON: level MAX_LEVEL; req=0 -> FALL on the next edge.
REQ-016 FALL: level-1 on each tick; the tick that makes level 0 -> OFF; req=1 -> RISE on the next edge.
REQ-017 Level SHALL never wrap: no increment at MAX_LEVEL, no decrement at 0.
REQ-018 When req changes in the same cycle as a tick, the step SHALL follow the current state and the transition SHALL follow req.
REQ-019 Each channel's pwm output SHALL be registered as (pwm_cnt < duty), one xclk of latency; duty = level with gamma disabled.
REQ-020 duty = MAX_LEVEL SHALL give a constant 1; duty = 0 SHALL give a constant 0.
REQ-021 Channels SHALL be fully independent apart from the shared tick and PWM counter.
REQ-022 busy SHALL be registered; (RISE|FALL on either channel) is visible at the following edge.

Reset
REQ-023 While sys_rst is high at a rising xclk, the block SHALL clear the prescaler, PWM counter and both levels, set both FSMs to OFF, and drive red_pwm, green_pwm and busy to 0.
REQ-024 Reset mid-ramp SHALL abort immediately, with no partial step.
REQ-025 After sys_rst falls, the block SHALL sample req on the first edge.

Configuration
REQ-026 With PIF_LED_FADER_GAMMA_EN defined, duty SHALL be (level*level) >> PWM_BITS (2*PWM_BITS-bit product, truncated), except that level = MAX_LEVEL SHALL force duty = MAX_LEVEL.
REQ-027 Without PIF_LED_FADER_GAMMA_EN, duty SHALL equal level and no multiplier SHALL be synthesised.

Structure
REQ-028 Package pif_led_pkg SHALL hold the fade-state enum typedef (OFF, RISE, ON, FALL) and the default PWM_BITS/STEP_DIV constants.
REQ-029 The per-channel FSM, level register, duty mapping and output register SHALL be sub-module pif_fade_channel, instantiated twice.
REQ-030 The prescaler and PWM counter SHALL live in pif_led_fader and be shared by both instances.

Verification (PWM_BITS=4 so MAX_LEVEL=15, STEP_DIV=2, unless noted)
REQ-031 Hold sys_rst high 3 cycles with reqs=1 -> red_pwm=green_pwm=busy=0 and both FSMs OFF throughout; first edge after release -> RISE.
REQ-032 red_req held 1 from reset -> level reaches 15 after 15 ticks (30 cycles), then ON; busy falls; red_pwm constantly 1; green_pwm constantly 0.
REQ-033 red_req=1 for 10 cycles then 0 -> level peaks at 5, descends to 0 without underflow, FSM returns to OFF, red_pwm stays 0 thereafter.
REQ-034 Freeze level at 8 (STEP_DIV large) -> red_pwm high for exactly 8 of every 15 cycles; with PIF_LED_FADER_GAMMA_EN, exactly 4 of every 15.
REQ-035 Assert sys_rst mid-RISE at level 6 -> next edge level 0, outputs 0, busy 0.
REQ-036 red_req toggled on a tick cycle, green_req constant 1 -> red obeys REQ-018; green ramp is unperturbed.

Source files
------------

// File: rtl/pif_led_pkg.sv
// Shared types and default constants for the two-channel LED fader.
// The fade-state enum is used by every channel instance so that state
// encodings stay identical across the design.
package pif_led_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fadeStateT;

  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_STEP_DIV = 4096;

endpackage

// File: rtl/pif_fade_channel.sv
// One fade channel: OFF/RISE/ON/FALL state machine, brightness level,
// duty mapping and registered PWM output.
// Optional gamma curve: define PIF_LED_FADER_GAMMA_EN to map the level
// through (level*level) >> PWM_BITS; otherwise the duty is the level itself.
module pif_fade_channel
  import pif_led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                xclk,
  input  logic                sys_rst,
  input  logic                i_tick,
  input  logic [PWM_BITS-1:0] i_pwmCnt,
  input  logic                i_req,
  output logic                o_pwm,
  output logic                o_active
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL  = '1;
  localparam logic [PWM_BITS-1:0] ZERO_LEVEL = '0;
  localparam logic [PWM_BITS-1:0] ONE_LEVEL  = PWM_BITS'(1);

  fadeStateT           r_state;
  fadeStateT           w_nextState;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_nextLevel;
  logic [PWM_BITS-1:0] w_duty;
  logic                r_pwm;

  // State register; reset drops straight to OFF with no partial step.
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      r_state <= OFF;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Level register, stepped by the next-state logic on prescaler ticks.
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      r_level <= '0;
    end else begin
      r_level <= w_nextLevel;
    end
  end

  // Next state and level: the step follows the current state, the transition follows req.
  always_comb begin
    w_nextState = r_state;
    w_nextLevel = r_level;
    case (r_state)
      OFF: begin
        if (i_req) begin
          w_nextState = RISE;
        end
      end
      RISE: begin
        if (i_tick && (r_level != MAX_LEVEL)) begin
          w_nextLevel = r_level + ONE_LEVEL;
        end
        if (!i_req) begin
          w_nextState = FALL;
        end else if (i_tick && (r_level >= (MAX_LEVEL - ONE_LEVEL))) begin
          w_nextState = ON;
        end
      end
      ON: begin
        if (!i_req) begin
          w_nextState = FALL;
        end
      end
      FALL: begin
        if (i_tick && (r_level != ZERO_LEVEL)) begin
          w_nextLevel = r_level - ONE_LEVEL;
        end
        if (i_req) begin
          w_nextState = RISE;
        end else if (i_tick && (r_level <= ONE_LEVEL)) begin
          w_nextState = OFF;
        end
      end
      default: begin
        w_nextState = OFF;
      end
    endcase
  end

  // Output decode: a channel is active while it is ramping in either direction.
  always_comb begin
    o_active = (r_state == RISE) || (r_state == FALL);
  end

`ifdef PIF_LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_square;

  // Gamma duty: square the level and keep the top half; full level stays full on.
  always_comb begin
    w_square = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
    if (r_level == MAX_LEVEL) begin
      w_duty = MAX_LEVEL;
    end else begin
      w_duty = w_square[2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  // Linear duty: the level drives the comparator directly.
  always_comb begin
    w_duty = r_level;
  end
`endif

  // Registered PWM compare; the counter never reaches MAX_LEVEL so full duty is solid on.
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (i_pwmCnt < w_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pif_led_fader.sv
// Two-channel (red/green) LED fader. A shared prescaler paces the fade
// steps and a shared PWM counter feeds both channel comparators.
// Optional gamma curve: define PIF_LED_FADER_GAMMA_EN (handled in pif_fade_channel).
module pif_led_fader
  import pif_led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic xclk,
  input  logic sys_rst,
  input  logic red_req,
  input  logic green_req,
  output logic red_pwm,
  output logic green_pwm,
  output logic busy
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  logic [PRE_W-1:0]    r_preCnt;
  logic                w_tick;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic                w_redActive;
  logic                w_greenActive;
  logic                r_busy;

  assign w_tick = (r_preCnt == PRE_LAST);

  // Step prescaler: counts 0..STEP_DIV-1 and wraps, tick on the last count.
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      r_preCnt <= '0;
    end else if (w_tick) begin
      r_preCnt <= '0;
    end else begin
      r_preCnt <= r_preCnt + PRE_W'(1);
    end
  end

  // PWM counter: counts 0..MAX_LEVEL-1 so the period is MAX_LEVEL cycles.
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      r_pwmCnt <= '0;
    end else if (r_pwmCnt == PWM_LAST) begin
      r_pwmCnt <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
    end
  end

  // Busy flag, registered from the channel states.
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_redActive || w_greenActive;
    end
  end

  assign busy = r_busy;

  pif_fade_channel #(
    .PWM_BITS (PWM_BITS)
  ) u_red (
    .xclk     (xclk),
    .sys_rst  (sys_rst),
    .i_tick   (w_tick),
    .i_pwmCnt (r_pwmCnt),
    .i_req    (red_req),
    .o_pwm    (red_pwm),
    .o_active (w_redActive)
  );

  pif_fade_channel #(
    .PWM_BITS (PWM_BITS)
  ) u_green (
    .xclk     (xclk),
    .sys_rst  (sys_rst),
    .i_tick   (w_tick),
    .i_pwmCnt (r_pwmCnt),
    .i_req    (green_req),
    .o_pwm    (green_pwm),
    .o_active (w_greenActive)
  );

endmodule

// File: tb/tb_pif_led_fader.sv
// Self-checking bench for pif_led_fader (PWM_BITS=4, STEP_DIV=2), plus a
// slow-stepping instance (STEP_DIV=64) used to hold a level long enough to
// measure duty. Honours PIF_LED_FADER_GAMMA_EN in its reference duty.
module tb_pif_led_fader;

  localparam int PB      = 4;
  localparam int SD      = 2;
  localparam int MAXL    = 15;
  localparam int SLOW_SD = 64;

  logic xclk = 1'b0;
  logic sys_rst, red_req, green_req;
  logic red_pwm, green_pwm, busy;
  logic slowRst, slowRed, slowGreen;
  logic slowRedPwm, slowGreenPwm, slowBusy;

  // Free-running 10-unit clock shared by both instances.
  always #5 xclk = ~xclk;

  pif_led_fader #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .xclk      (xclk),
    .sys_rst   (sys_rst),
    .red_req   (red_req),
    .green_req (green_req),
    .red_pwm   (red_pwm),
    .green_pwm (green_pwm),
    .busy      (busy)
  );

  pif_led_fader #(.PWM_BITS(PB), .STEP_DIV(SLOW_SD)) dutSlow (
    .xclk      (xclk),
    .sys_rst   (slowRst),
    .red_req   (slowRed),
    .green_req (slowGreen),
    .red_pwm   (slowRedPwm),
    .green_pwm (slowGreenPwm),
    .busy      (slowBusy)
  );

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [2:0] outs;
    string      name;
  } expT;
  expT scoreQ[$];

  typedef struct {
    logic       rst;
    logic       redReq;
    logic       greenReq;
    int         cycles;
    logic       chk;
    logic [2:0] endOuts;
  } vecT;
  vecT vecTab[6];

  // Behavioural reference: 0=off 1=rise 2=on 3=fall
  int mPre, mCnt, mBusy;
  int mState[2];
  int mLevel[2];
  int mPwm[2];

  logic [0:19] redPat = 20'b11111110110110011111;

  function automatic int benchDuty(input int lvl);
`ifdef PIF_LED_FADER_GAMMA_EN
    if (lvl == MAXL) return MAXL;
    return (lvl * lvl) / 16;
`else
    return lvl;
`endif
  endfunction

  task automatic modelStep(input logic rst, input logic rq, input logic gq);
    int  tick, nb, lvl, st;
    logic req;
    if (rst) begin
      mPre = 0; mCnt = 0; mBusy = 0;
      for (int c = 0; c < 2; c++) begin
        mState[c] = 0; mLevel[c] = 0; mPwm[c] = 0;
      end
    end else begin
      tick = (mPre == SD - 1) ? 1 : 0;
      nb = 0;
      for (int c = 0; c < 2; c++)
        if (mState[c] == 1 || mState[c] == 3) nb = 1;
      for (int c = 0; c < 2; c++) begin
        mPwm[c] = (mCnt < benchDuty(mLevel[c])) ? 1 : 0;
        req = (c == 0) ? rq : gq;
        lvl = mLevel[c];
        st  = mState[c];
        if (tick == 1 && st == 1 && lvl < MAXL) lvl++;
        if (tick == 1 && st == 3 && lvl > 0) lvl--;
        if (req) begin
          if (st == 0 || st == 3) st = 1;
          else if (st == 1 && tick == 1 && lvl == MAXL) st = 2;
        end else begin
          if (st == 1 || st == 2) st = 3;
          else if (st == 3 && tick == 1 && lvl == 0) st = 0;
        end
        mLevel[c] = lvl;
        mState[c] = st;
      end
      mBusy = nb;
      mPre  = (tick == 1) ? 0 : mPre + 1;
      mCnt  = (mCnt == MAXL - 1) ? 0 : mCnt + 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle, queue the model prediction, then compare after the edge.
  task automatic applyStimulus(input logic rst, input logic rq, input logic gq, input string name);
    expT e, got;
    sys_rst   = rst;
    red_req   = rq;
    green_req = gq;
    modelStep(rst, rq, gq);
    e.outs = {mPwm[0][0], mPwm[1][0], mBusy[0]};
    e.name = name;
    scoreQ.push_back(e);
    @(posedge xclk);
    #1;
    if (scoreQ.size() == 0) begin
      checkOutput({name, " queue empty"}, 32'd0, 32'd1);
    end else begin
      got = scoreQ.pop_front();
      checkOutput(got.name, {29'd0, red_pwm, green_pwm, busy}, {29'd0, got.outs});
    end
  endtask

  // Main sequence: table segments, then hand-written corner cases.
  initial begin
    int highs, gHighs, bHighs;
    sys_rst = 1'b1; red_req = 1'b0; green_req = 1'b0;
    slowRst = 1'b1; slowRed = 1'b0; slowGreen = 1'b0;

    vecTab[0] = '{1'b1, 1'b1, 1'b1, 3,  1'b1, 3'b000};
    vecTab[1] = '{1'b0, 1'b1, 1'b0, 40, 1'b1, 3'b100};
    vecTab[2] = '{1'b0, 1'b0, 1'b0, 40, 1'b1, 3'b000};
    vecTab[3] = '{1'b1, 1'b0, 1'b0, 2,  1'b1, 3'b000};
    vecTab[4] = '{1'b0, 1'b1, 1'b0, 10, 1'b1, 3'b001};
    vecTab[5] = '{1'b0, 1'b0, 1'b0, 30, 1'b1, 3'b000};

    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < vecTab[s].cycles; c++)
        applyStimulus(vecTab[s].rst, vecTab[s].redReq, vecTab[s].greenReq, $sformatf("seg%0d", s));
      if (vecTab[s].chk)
        checkOutput($sformatf("seg%0d end", s), {29'd0, red_pwm, green_pwm, busy}, {29'd0, vecTab[s].endOuts});
    end

    // Reset with both requests high, then ramp both to level 6 and reset mid-rise.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, "rst hold");
      checkOutput("rst hold outs", {29'd0, red_pwm, green_pwm, busy}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, "release e1");
    applyStimulus(1'b0, 1'b1, 1'b1, "release e2");
    checkOutput("busy after release", {29'd0, red_pwm, green_pwm, busy}, 32'd1);
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b1, 1'b1, "rise to 6");
    applyStimulus(1'b1, 1'b1, 1'b1, "mid-rise rst");
    checkOutput("mid-rise rst outs", {29'd0, red_pwm, green_pwm, busy}, 32'd0);

    // Full ramp on red only, then measure a whole PWM period at full level.
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b1, 1'b0, "red ramp");
    highs = 0; gHighs = 0; bHighs = 0;
    for (int c = 0; c < MAXL; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, "red on");
      highs  += int'(red_pwm);
      gHighs += int'(green_pwm);
      bHighs += int'(busy);
    end
    checkOutput("red on highs", highs, MAXL);
    checkOutput("green off highs", gHighs, 0);
    checkOutput("busy when on", bHighs, 0);

    // Red toggled around tick cycles while green ramps undisturbed.
    applyStimulus(1'b1, 1'b0, 1'b0, "rst pre-toggle");
    applyStimulus(1'b1, 1'b0, 1'b0, "rst pre-toggle");
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, redPat[k], 1'b1, "toggle");
    for (int k = 0; k < 24; k++) applyStimulus(1'b0, 1'b0, 1'b1, "green ramp");
    gHighs = 0; highs = 0;
    for (int c = 0; c < MAXL; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, "green on");
      gHighs += int'(green_pwm);
      highs  += int'(red_pwm);
    end
    checkOutput("green on highs", gHighs, MAXL);
    checkOutput("red settled off", highs, 0);

    // Slow instance: level 8 holds for 64 cycles, long enough to measure duty.
    @(posedge xclk); #1;
    @(posedge xclk); #1;
    slowRst = 1'b0;
    slowRed = 1'b1;
    repeat (539) @(posedge xclk);
    highs = 0; gHighs = 0;
    for (int c = 0; c < MAXL; c++) begin
      @(posedge xclk); #1;
      highs  += int'(slowRedPwm);
      gHighs += int'(slowGreenPwm);
    end
`ifdef PIF_LED_FADER_GAMMA_EN
    checkOutput("level8 highs", highs, 4);
`else
    checkOutput("level8 highs", highs, 8);
`endif
    checkOutput("slow green highs", gHighs, 0);
    checkOutput("slow busy", {31'd0, slowBusy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
